// File: rtl/tx_lane_scheduler_pkg.sv
// ============================================================================
// Module      : tx_lane_scheduler_pkg
// Description : Shared state encoding and defaults for the TX lane scheduler,
//               serializer and deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tx_lane_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } sched_state_t;

    localparam logic [7:0] COM_SYMBOL_DEF  = 8'hBC;
    localparam int         INIT_SLOTS_DEF  = 4;
    localparam int         IDLE_FRAMES_DEF = 2;
    localparam int         LANES           = 4;

    function automatic logic any_valid(input logic [LANES-1:0] v);
        return |v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_snapshot.sv
// ============================================================================
// Module      : frame_snapshot
// Description : Free-running 2-bit slot counter plus a per-frame capture of
//               all lane bytes and valids on the slot-3 edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_snapshot
    import tx_lane_scheduler_pkg::*;
(
    input  logic                  clk_4f,
    input  logic                  reset,
    input  logic                  run,
    input  logic [LANES-1:0][7:0] lane_data,
    input  logic [LANES-1:0]      lane_valid,
    output logic [1:0]            slot,
    output logic                  boundary,
    output logic [LANES-1:0][7:0] snap_data,
    output logic [LANES-1:0]      snap_valid
);

    logic [1:0]            r_slot;
    logic [LANES-1:0][7:0] r_snap_data;
    logic [LANES-1:0]      r_snap_valid;

    assign slot       = r_slot;
    assign boundary   = run && (r_slot == 2'd3);
    assign snap_data  = r_snap_data;
    assign snap_valid = r_snap_valid;

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            r_slot       <= 2'd0;
            r_snap_data  <= '0;
            r_snap_valid <= '0;
        end else if (run) begin
            r_slot <= r_slot + 2'd1;
            if (boundary) begin
                r_snap_data  <= lane_data;
                r_snap_valid <= lane_valid;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tx_lane_scheduler.sv
// ============================================================================
// Module      : tx_lane_scheduler
// Description : Four-lane TX slot scheduler: INIT/IDLE comma fill, ACTIVE
//               frame emission from a per-frame lane snapshot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_lane_scheduler
    import tx_lane_scheduler_pkg::*;
#(
    parameter logic [7:0] COM_SYMBOL  = COM_SYMBOL_DEF,
    parameter int         INIT_SLOTS  = INIT_SLOTS_DEF,
    parameter int         IDLE_FRAMES = IDLE_FRAMES_DEF
)(
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] data_0p,
    input  logic [7:0] data_1p,
    input  logic [7:0] data_2p,
    input  logic [7:0] data_3p,
    input  logic       valid_0p,
    input  logic       valid_1p,
    input  logic       valid_2p,
    input  logic       valid_3p,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [1:0] lane_sel,
    output logic       frame_start,
    output logic       idle_out,
    output logic       active
);

    // INIT_SLOTS is expected to be a multiple of 4; INIT is counted in frames.
    localparam int INIT_FRAMES = (INIT_SLOTS / 4 < 1) ? 1 : INIT_SLOTS / 4;
    localparam int IW          = $clog2(INIT_FRAMES + 1);
    localparam int EW          = $clog2(IDLE_FRAMES + 1);

    localparam logic [IW-1:0] c_init_last   = IW'(INIT_FRAMES - 1);
    localparam logic [EW:0]   c_idle_frames = (EW + 1)'(IDLE_FRAMES);

    sched_state_t r_state, w_state_nxt;
    logic [IW-1:0] r_init_cnt, w_init_nxt;
    logic [EW-1:0] r_empty_cnt, w_empty_nxt;
    logic [EW:0]   w_empty_inc;

    logic [LANES-1:0][7:0] w_lane_data;
    logic [LANES-1:0]      w_lane_valid;
    logic [LANES-1:0][7:0] w_snap_data;
    logic [LANES-1:0]      w_snap_valid;
    logic [1:0]            w_slot;
    logic                  w_boundary;
    logic                  w_run;
    logic                  w_any;

    logic [7:0] w_data, r_data;
    logic       w_valid, r_valid;
    logic [1:0] w_lane, r_lane;
    logic       w_fs, r_fs;
    logic       w_idle, r_idle;
    logic       w_active, r_active;

    assign w_lane_data  = {data_3p, data_2p, data_1p, data_0p};
    assign w_lane_valid = {valid_3p, valid_2p, valid_1p, valid_0p};
    assign w_run        = (r_state != ST_RESET);
    assign w_any        = any_valid(w_lane_valid);
    assign w_empty_inc  = {1'b0, r_empty_cnt} + {{EW{1'b0}}, 1'b1};

    frame_snapshot u_frame_snapshot (
        .clk_4f     (clk_4f),
        .reset      (reset),
        .run        (w_run),
        .lane_data  (w_lane_data),
        .lane_valid (w_lane_valid),
        .slot       (w_slot),
        .boundary   (w_boundary),
        .snap_data  (w_snap_data),
        .snap_valid (w_snap_valid)
    );

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            r_state     <= ST_RESET;
            r_init_cnt  <= '0;
            r_empty_cnt <= '0;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_lane      <= 2'd0;
            r_fs        <= 1'b0;
            r_idle      <= 1'b1;
            r_active    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_cnt  <= w_init_nxt;
            r_empty_cnt <= w_empty_nxt;
            r_data      <= w_data;
            r_valid     <= w_valid;
            r_lane      <= w_lane;
            r_fs        <= w_fs;
            r_idle      <= w_idle;
            r_active    <= w_active;
        end
    end

    // Transitions are evaluated on the same edge that captures the snapshot,
    // so the decision uses the live lane valids being captured.
    always_comb begin
        w_state_nxt = r_state;
        w_init_nxt  = r_init_cnt;
        w_empty_nxt = r_empty_cnt;
        case (r_state)
            ST_RESET: begin
                w_state_nxt = ST_INIT;
                w_init_nxt  = '0;
                w_empty_nxt = '0;
            end
            ST_INIT: begin
                if (w_boundary) begin
                    if (r_init_cnt == c_init_last) begin
                        w_init_nxt  = '0;
                        w_state_nxt = w_any ? ST_ACTIVE : ST_IDLE;
                    end else begin
                        w_init_nxt = r_init_cnt + {{(IW-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_IDLE: begin
                if (w_boundary && w_any) begin
                    w_state_nxt = ST_ACTIVE;
                    w_empty_nxt = '0;
                end
            end
            ST_ACTIVE: begin
                if (w_boundary) begin
                    if (w_any) begin
                        w_empty_nxt = '0;
                    end else if (w_empty_inc == c_idle_frames) begin
                        w_empty_nxt = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_empty_nxt = w_empty_inc[EW-1:0];
                    end
                end
            end
            default: begin
                w_state_nxt = ST_RESET;
            end
        endcase
    end

    always_comb begin
        w_data   = 8'h00;
        w_valid  = 1'b0;
        w_lane   = 2'd0;
        w_fs     = 1'b0;
        w_idle   = 1'b1;
        w_active = 1'b0;
        case (r_state)
            ST_INIT, ST_IDLE: begin
                w_data = COM_SYMBOL;
                w_lane = w_slot;
                w_fs   = (w_slot == 2'd0);
            end
            ST_ACTIVE: begin
                w_data   = w_snap_valid[w_slot] ? w_snap_data[w_slot] : COM_SYMBOL;
                w_valid  = w_snap_valid[w_slot];
                w_lane   = w_slot;
                w_fs     = (w_slot == 2'd0);
                w_idle   = 1'b0;
                w_active = 1'b1;
            end
            default: begin
                w_data = 8'h00;
            end
        endcase
    end

    assign data_out    = r_data;
    assign valid_out   = r_valid;
    assign lane_sel    = r_lane;
    assign frame_start = r_fs;
    assign idle_out    = r_idle;
    assign active      = r_active;

endmodule

`default_nettype wire

// File: tb/tb_tx_lane_scheduler.sv
// ============================================================================
// Module      : tb_tx_lane_scheduler
// Description : Scoreboard bench for tx_lane_scheduler with a cycle-count
//               based reference model and randomized lane traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tx_lane_scheduler;

    localparam logic [7:0] COM         = 8'hBC;
    localparam int         INIT_SLOTS  = 4;
    localparam int         IDLE_FRAMES = 2;

    logic       clk_4f = 1'b0;
    logic       reset  = 1'b0;
    logic [7:0] d [4];
    logic [3:0] v      = 4'h0;

    logic [7:0] data_out;
    logic       valid_out;
    logic [1:0] lane_sel;
    logic       frame_start;
    logic       idle_out;
    logic       active;

    tx_lane_scheduler #(
        .COM_SYMBOL  (COM),
        .INIT_SLOTS  (INIT_SLOTS),
        .IDLE_FRAMES (IDLE_FRAMES)
    ) dut (
        .clk_4f      (clk_4f),
        .reset       (reset),
        .data_0p     (d[0]),
        .data_1p     (d[1]),
        .data_2p     (d[2]),
        .data_3p     (d[3]),
        .valid_0p    (v[0]),
        .valid_1p    (v[1]),
        .valid_2p    (v[2]),
        .valid_3p    (v[3]),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .lane_sel    (lane_sel),
        .frame_start (frame_start),
        .idle_out    (idle_out),
        .active      (active)
    );

    always #5 clk_4f = ~clk_4f;

    // Expected vector: {data[7:0], valid, lane[1:0], frame_start, idle, active}
    logic [13:0] exp_q [$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode 0=reset,1=init,2=idle,3=active; age = cycles since
    // the first post-reset cycle, so the slot is simply age mod 4.
    int         m_mode  = 0;
    int         m_age   = 0;
    int         m_empty = 0;
    logic [7:0] m_sd [4];
    logic [3:0] m_sv    = 4'h0;

    task automatic model_edge();
        logic [13:0] e;
        int          s;
        e = {8'h00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
        if (!reset) begin
            m_mode = 0; m_empty = 0; m_sv = 4'h0;
            for (int i = 0; i < 4; i++) m_sd[i] = 8'h00;
        end else if (m_mode == 0) begin
            m_mode = 1; m_age = 0;
        end else begin
            s = m_age % 4;
            if (m_mode == 3)
                e = {m_sv[s] ? m_sd[s] : COM, m_sv[s], 2'(s), (s == 0), 1'b0, 1'b1};
            else
                e = {COM, 1'b0, 2'(s), (s == 0), 1'b1, 1'b0};
            if (s == 3) begin
                for (int i = 0; i < 4; i++) m_sd[i] = d[i];
                m_sv = v;
                if (m_mode == 1) begin
                    if (m_age == INIT_SLOTS - 1) m_mode = (v != 0) ? 3 : 2;
                end else if (m_mode == 2) begin
                    if (v != 0) begin m_mode = 3; m_empty = 0; end
                end else begin
                    if (v != 0) m_empty = 0;
                    else begin
                        m_empty++;
                        if (m_empty == IDLE_FRAMES) begin m_mode = 2; m_empty = 0; end
                    end
                end
            end
            m_age++;
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] e, input logic [3:0] vv);
        reset = r; d[0] = a; d[1] = b; d[2] = c; d[3] = e; v = vv;
        model_edge();
        @(negedge clk_4f);
    endtask

    // Monitor: the DUT presents one output slot per cycle.
    initial begin
        logic [13:0] ex, got;
        forever begin
            @(posedge clk_4f);
            #1;
            if (exp_q.size() > 0) begin
                ex  = exp_q.pop_front();
                got = {data_out, valid_out, lane_sel, frame_start, idle_out, active};
                n_cmp++;
                if (got !== ex) begin
                    n_bad++;
                    $display("FAIL out t=%0t got data=%h v=%b lane=%0d fs=%b idle=%b act=%b required data=%h v=%b lane=%0d fs=%b idle=%b act=%b",
                             $time, got[13:6], got[5], got[4:3], got[2], got[1], got[0],
                             ex[13:6], ex[5], ex[4:3], ex[2], ex[1], ex[0]);
                end
            end
        end
    end

    initial begin
        int         vmode;
        logic [3:0] vv;
        for (int i = 0; i < 4; i++) begin d[i] = 8'h00; m_sd[i] = 8'h00; end
        // Reset, INIT, then IDLE with no traffic.
        repeat (3) step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
        repeat (5) step(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
        repeat (4) step(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
        // Full frame, single-lane frame, then empty/valid/empty, then drain to IDLE.
        repeat (4) step(1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 4'hF);
        repeat (4) step(1'b1, 8'h00, 8'h00, 8'hA5, 8'h00, 4'b0100);
        repeat (4) step(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
        repeat (4) step(1'b1, 8'h55, 8'h66, 8'h77, 8'h88, 4'hF);
        repeat (4) step(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
        repeat (12) step(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
        // Back to ACTIVE, then reset mid-frame.
        repeat (4) step(1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 4'hF);
        repeat (4) step(1'b1, 8'h99, 8'h98, 8'h97, 8'h96, 4'hF);
        repeat (2) step(1'b1, 8'h12, 8'h34, 8'h56, 8'h78, 4'hF);
        repeat (2) step(1'b0, 8'h12, 8'h34, 8'h56, 8'h78, 4'hF);
        repeat (10) step(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
        // Randomized traffic with bursts of silence and occasional resets.
        vmode = 1;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(15, 0) == 0) vmode = $urandom_range(2, 0);
            case (vmode)
                0:       vv = 4'h0;
                1:       vv = 4'($urandom_range(15, 0));
                default: vv = 4'hF;
            endcase
            step(($urandom_range(299, 0) != 0),
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), vv);
        end
        @(posedge clk_4f);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
